// File: rtl/sample_streamer.sv
// sample_streamer: reads a run of sample RAM words and
// streams them gap-free to the delay beamformer.
module sample_streamer #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_samples,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   input  logic [DATA_W-1:0] mem_q,
   output logic [DATA_W-1:0] sample_value,
   output logic [IDX_W-1:0]  sample_index,
   output logic              sample_valid,
   output logic              startbeamformer
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FINISH
   } state_t;

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   num_q;
   logic [ADDR_W:0]   rd_cnt;
   logic [ADDR_W:0]   out_cnt;
   logic [RD_LAT-1:0] tag;
   logic              tag_out;
   logic              accept;
   logic              accept_run;
   logic              last_issue;
   logic              drained;
   logic              kill;

   // rd_cnt holds the next address to issue
   assign tag_out    = tag[RD_LAT-1];
   assign last_issue = (rd_cnt == num_q);
   assign drained    = (tag == '0) && (out_cnt == num_q);
   assign startbeamformer = sample_valid;

   // next-state and control decode
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      accept_run = 1'b0;
      kill       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (num_samples == '0) begin
                  state_nxt = FINISH;
               end else begin
                  accept_run = 1'b1;
                  state_nxt  = ISSUE;
               end
            end
         end
         ISSUE: begin
            busy = 1'b1;
            if (abort) begin
               kill      = 1'b1;
               state_nxt = IDLE;
            end else if (last_issue) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               kill      = 1'b1;
               state_nxt = IDLE;
            end else if (drained) begin
               state_nxt = FINISH;
            end
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // read issue: one address per clock from 0 to N-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q    <= '0;
         rd_cnt   <= '0;
         mem_addr <= '0;
         mem_rden <= 1'b0;
      end else if (kill) begin
         mem_rden <= 1'b0;
      end else if (accept) begin
         num_q <= num_samples;
         if (accept_run) begin
            mem_addr <= '0;
            mem_rden <= 1'b1;
            rd_cnt   <= CNT_ONE;
         end
      end else if (state == ISSUE) begin
         if (last_issue) begin
            mem_rden <= 1'b0;
         end else begin
            mem_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt   <= rd_cnt + CNT_ONE;
         end
      end
   end

   // valid tags travel alongside reads in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag <= '0;
      end else if (kill) begin
         tag <= '0;
      end else begin
         tag[0] <= mem_rden;
         for (int i = 1; i < RD_LAT; i++)
            tag[i] <= tag[i-1];
      end
   end

   // capture returning data; value/index hold when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_value <= '0;
         sample_index <= '0;
         sample_valid <= 1'b0;
         out_cnt      <= '0;
      end else if (kill) begin
         sample_valid <= 1'b0;
      end else if (accept) begin
         sample_valid <= 1'b0;
         out_cnt      <= '0;
      end else begin
         sample_valid <= tag_out;
         if (tag_out) begin
            sample_value <= mem_q;
            sample_index <= IDX_W'(out_cnt);
            out_cnt      <= out_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: directed and random runs against
// a timing model derived from the stream rules.
module tb_sample_streamer;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 16;
   localparam int RD_LAT = 2;
   localparam int NONE   = 1 << 30;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W:0]   num_samples = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rden;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] sample_value;
   logic [IDX_W-1:0]  sample_index;
   logic              sample_valid;
   logic              startbeamformer;

   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [DATA_W-1:0] rp [RD_LAT];

   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] last_val = '0;
   int last_idx = 0;

   sample_streamer #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W),
      .RD_LAT(RD_LAT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .num_samples    (num_samples),
      .busy           (busy),
      .done           (done),
      .mem_addr       (mem_addr),
      .mem_rden       (mem_rden),
      .mem_q          (mem_q),
      .sample_value   (sample_value),
      .sample_index   (sample_index),
      .sample_valid   (sample_valid),
      .startbeamformer(startbeamformer)
   );

   always #5 clk = ~clk;

   // RAM with RD_LAT-cycle read; poison when not enabled
   always @(posedge clk) begin
      rp[0] <= mem_rden ? mem[mem_addr] : 32'hDEAD_BEEF;
      for (int i = 1; i < RD_LAT; i++)
         rp[i] <= rp[i-1];
   end
   assign mem_q = rp[RD_LAT-1];

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // cycle j is the cycle after edge E0+j
   task automatic check_cycle(input int j,
                              input int n,
                              input int stop);
      bit run;
      bit v;
      bit b;
      bit d;
      bit r;
      run = (j < stop);
      v = run && n > 0 && j >= RD_LAT + 1
          && j <= n + RD_LAT;
      b = run && n > 0 && j <= n + RD_LAT;
      d = run && (n == 0 ? j == 0
                         : j == n + RD_LAT + 1);
      r = run && j < n;
      if (v) begin
         last_idx = j - RD_LAT - 1;
         last_val = mem[last_idx];
      end
      chk("valid", sample_valid, v);
      chk("startbf", startbeamformer, v);
      chk("busy", busy, b);
      chk("done", done, d);
      chk("rden", mem_rden, r);
      if (r) chk("addr", mem_addr, j);
      chk("value", sample_value, last_val);
      chk("index", sample_index, last_idx);
   endtask

   task automatic do_run(input int n, input int p1,
                         input int p2, input int ab,
                         input int ncyc);
      @(negedge clk);
      start = 1'b1;
      num_samples = n[ADDR_W:0];
      @(posedge clk);
      for (int j = 0; j < ncyc; j++) begin
         @(negedge clk);
         check_cycle(j, n, ab < 0 ? NONE : ab);
         start = (j == p1) || (j == p2)
                 || (j == ab - 1);
         abort = (j == ab - 1);
         num_samples = ADDR_W'(j + 3);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++)
         mem[a] = DATA_W'(32'h1000 + a);

      #2 rst_n = 1'b0;
      #1;
      check_cycle(0, 0, 0);
      chk("rst_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic run, N=4
      do_run(4, -1, -1, -1, 4 + RD_LAT + 4);
      // zero length
      do_run(0, -1, -1, -1, 5);
      // start while streaming and on the done cycle
      do_run(10, 5, 10 + RD_LAT + 1, -1,
             10 + RD_LAT + 5);

      for (int a = 0; a < (1 << ADDR_W); a++)
         mem[a] = $urandom;

      // full depth
      do_run(1 << ADDR_W, -1, -1, -1,
             (1 << ADDR_W) + RD_LAT + 4);

      // random lengths
      for (int k = 0; k < 4; k++) begin
         int n;
         n = $urandom_range(1, 64);
         do_run(n, -1, -1, -1, n + RD_LAT + 4);
      end

      // abort with simultaneous start
      do_run(8, -1, -1, RD_LAT + 4, 12);
      do_run(5, -1, -1, -1, 5 + RD_LAT + 4);

      // mid-run reset
      @(negedge clk);
      start = 1'b1;
      num_samples = 6;
      @(posedge clk);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check_cycle(j, 6, NONE);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      last_val = '0;
      last_idx = 0;
      check_cycle(0, 0, 0);
      chk("rst_addr", mem_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check_cycle(j, 0, 0);
      end
      do_run(4, -1, -1, -1, 4 + RD_LAT + 4);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
